stopwatch_lap_core: RTL

Parametrised successor to the fixed 4-digit, 0.1 s stopwatch. It runs from the full-rate system clock and uses an internal tick prescaler, not a divided clock. It provides N-digit BCD counting, a lap/split display freeze, a count-down mode with preset load and done pulse, and sticky overflow. It sits between the button debouncers and the seven-segment display driver.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_bcd_digit.sv | 47 ++++
 rtl/stopwatch_lap_core.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM state type and event-priority helper for the lap stopwatch.
// Event priority is clear > start_stop > lap; the count tick is handled separately.
package stopwatch_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    SW_STOPPED,
    SW_RUNNING
  } sw_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_LAP,
    EV_START_STOP,
    EV_CLEAR
  } sw_event_e;

  function automatic sw_event_e sw_top_event(input logic clr, input logic ss, input logic lp);
    if (clr) begin
      return EV_CLEAR;
    end else if (ss) begin
      return EV_START_STOP;
    end else if (lp) begin
      return EV_LAP;
    end
    return EV_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch counter with synchronous load and up/down step.
// carry_out/borrow_out are combinational, so a chain of digits ripples in one cycle.
module stopwatch_bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] value,
  output logic [BCD_W-1:0] value_next,
  output logic             carry_out,
  output logic             borrow_out
);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == '0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;
  assign carry_out  = en && up && (value_q == BCD_MAX);
  assign borrow_out = en && !up && (value_q == '0);

endmodule

// File: rtl/stopwatch_lap_core.sv
// N-digit BCD stopwatch with prescaled tick, lap freeze, count-down with done pulse
// and sticky overflow. All button inputs are debounced levels; actions fire on rising edges.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int TICK_DIV   = 10_000_000,
  localparam int PRESCALE_W = $clog2(TICK_DIV)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_stop,
  input  logic                        clear,
  input  logic                        lap,
  input  logic                        mode_down,
  input  logic [BCD_W*NUM_DIGITS-1:0] preset_bcd,
  output logic [BCD_W*NUM_DIGITS-1:0] display_bcd,
  output logic                        running,
  output logic                        lap_active,
  output logic                        overflow,
  output logic                        done
);

  localparam int                    CW           = BCD_W * NUM_DIGITS;
  localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TICK_DIV - 1);

  sw_state_e             state_q, state_d;
  logic                  mode_q, mode_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  lap_q, lap_d;
  logic [CW-1:0]         snap_q, snap_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         disp_q, disp_d;
  logic [2:0]            hist_q, hist_d;

  logic [CW-1:0]         count_q, count_d, load_val;
  logic [NUM_DIGITS:0]   chain;
  logic [NUM_DIGITS-1:0] preset_ok;
  logic                  ss_evt, clear_evt, lap_evt, tick, count_up;
  sw_event_e             ev;

  // hist bit order: {lap, clear, start_stop}
  assign hist_d    = {lap, clear, start_stop};
  assign ss_evt    = start_stop && !hist_q[0];
  assign clear_evt = clear && !hist_q[1];
  assign lap_evt   = lap && !hist_q[2];
  assign ev        = sw_top_event(clear_evt, ss_evt, lap_evt);

  assign count_up = !mode_q;
  assign tick     = (state_q == SW_RUNNING) && (presc_q == PRESCALE_MAX);
  assign load_val = mode_q ? preset_bcd : '0;
  assign chain[0] = tick && (ev != EV_CLEAR);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic carry, borrow;
    stopwatch_bcd_digit u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (chain[gi]),
      .up        (count_up),
      .load      (ev == EV_CLEAR),
      .load_val  (load_val[gi*BCD_W +: BCD_W]),
      .value     (count_q[gi*BCD_W +: BCD_W]),
      .value_next(count_d[gi*BCD_W +: BCD_W]),
      .carry_out (carry),
      .borrow_out(borrow)
    );
    assign chain[gi+1]   = count_up ? carry : borrow;
    assign preset_ok[gi] = (preset_bcd[gi*BCD_W +: BCD_W] <= BCD_MAX);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = (state_q == SW_STOPPED) ? mode_down : mode_q;
    presc_d = presc_q;
    lap_d   = lap_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (ev == EV_CLEAR) begin
      state_d = SW_STOPPED;
      presc_d = '0;
      lap_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (state_q == SW_RUNNING) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (ev == EV_START_STOP) begin
        if (state_q == SW_RUNNING) begin
          state_d = SW_STOPPED;
        end else if (!(mode_q && (count_q == '0))) begin
          state_d = SW_RUNNING;
        end
      end
      // Lap may coincide with start_stop; the snapshot always takes the pre-tick count.
      if (lap_evt) begin
        if (lap_q) begin
          lap_d = 1'b0;
        end else begin
          lap_d  = 1'b1;
          snap_d = count_q;
        end
      end
      if (count_up && chain[NUM_DIGITS]) begin
        ovf_d = 1'b1;
      end
      if (tick && mode_q && (count_d == '0)) begin
        state_d = SW_STOPPED;
        done_d  = 1'b1;
      end
    end
    disp_d = lap_d ? snap_d : count_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SW_STOPPED;
      mode_q  <= 1'b0;
      presc_q <= '0;
      lap_q   <= 1'b0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      hist_q  <= '1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      hist_q  <= hist_d;
    end
  end

  assign display_bcd = disp_q;
  assign running     = (state_q == SW_RUNNING);
  assign lap_active  = lap_q;
  assign overflow    = ovf_q;
  assign done        = done_q;

  a_preset_bcd : assert property (@(posedge clk) disable iff (!reset_n)
    ((ev == EV_CLEAR) && mode_q) |-> (&preset_ok));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(!count_up && chain[NUM_DIGITS]));

endmodule
